pipelined_prefix_adder: RTL and testbench

- Parametrised, pipelined successor to the 32-bit kpg/ppc fast adder.
- Uses a Kogge-Stone parallel-prefix tree over WIDTH bits, with a register bank after every PIPE_EVERY prefix levels.
- Has a valid/ready stream handshake with full-pipeline stall, an add/subtract mode, and carry-out and signed-overflow flags.
- Sits on the datapath as a drop-in, throughput-1 adder for multi-cycle arithmetic units.

---
 rtl/pipelined_prefix_adder.sv | 168 ++++++++++++++++
 tb/tb_pipelined_prefix_adder.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_prefix_adder.sv
// Pipelined Kogge-Stone adder/subtractor with a valid/ready stream handshake.
// Define ADDER_SAT_EN to saturate s on signed overflow (flags stay unsaturated).
module pipelined_prefix_adder #(
  parameter int WIDTH      = 32,
  parameter int PIPE_EVERY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int LEVELS = $clog2(WIDTH);
  localparam int NGRP   = (LEVELS + PIPE_EVERY - 1) / PIPE_EVERY;

  // One enable for the whole pipe: everything shifts or everything holds.
  logic            adv;
  logic [NGRP:0]   vld_q;

  assign out_valid = vld_q[NGRP];
  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv;

  // NOTE: state is updated with non-blocking assignments so every stage samples
  // the pre-edge value of its predecessor; blocking here would collapse stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   vld_q <= '0;
    else if (adv) vld_q <= {vld_q[NGRP-1:0], in_valid};
  end

  // Stage 0: operands after the subtract inversion, plus the carry-in.
  logic [WIDTH-1:0] a_s0_q, b_s0_q;
  logic             c0_s0_q;

  // NOTE: data registers are reset too (not only the valid bits) so s/cout/ovf
  // read zero after reset; the pipe is small, so this costs nothing notable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_s0_q  <= '0;
      b_s0_q  <= '0;
      c0_s0_q <= 1'b0;
    end else if (adv) begin
      a_s0_q  <= a;
      b_s0_q  <= sub ? ~b : b;
      c0_s0_q <= sub | cin;
    end
  end

  // Carry-in folded into bit 0's generate, so WIDTH positions need only LEVELS levels.
  logic [WIDTH-1:0] x0, g0;
  assign x0 = a_s0_q ^ b_s0_q;
  assign g0 = (a_s0_q & b_s0_q) | {{(WIDTH-1){1'b0}}, x0[0] & c0_s0_q};

  // src_*[k] is the input of prefix group k (stage 0 for k=0, else group k-1's register).
  logic [WIDTH-1:0] src_g  [NGRP];
  logic [WIDTH-1:0] src_p  [NGRP];
  logic [WIDTH-1:0] src_x  [NGRP];
  logic             src_c0 [NGRP];

  assign src_g[0]  = g0;
  assign src_p[0]  = x0;
  assign src_x[0]  = x0;
  assign src_c0[0] = c0_s0_q;

  logic [WIDTH-1:0] lvl_g [1:LEVELS];
  logic [WIDTH-1:0] lvl_p [1:LEVELS];

  for (genvar j = 0; j < LEVELS; j++) begin : g_lvl
    localparam int SPAN = 1 << j;
    logic [WIDTH-1:0] gi, pi, ng, np;

    if (j % PIPE_EVERY == 0) begin : g_from_reg
      assign gi = src_g[j / PIPE_EVERY];
      assign pi = src_p[j / PIPE_EVERY];
    end else begin : g_from_lvl
      assign gi = lvl_g[j];
      assign pi = lvl_p[j];
    end

    // NOTE: defaults first so every bit is assigned on every pass; no latches.
    always_comb begin
      ng = gi;
      np = pi;
      for (int i = SPAN; i < WIDTH; i++) begin
        ng[i] = gi[i] | (pi[i] & gi[i-SPAN]);
        np[i] = pi[i] & pi[i-SPAN];
      end
    end

    assign lvl_g[j+1] = ng;
    assign lvl_p[j+1] = np;
  end

  // The group-propagate after the final level feeds nothing.
  logic unused_final_p;
  assign unused_final_p = ^lvl_p[LEVELS];

  for (genvar k = 0; k < NGRP; k++) begin : g_grp
    localparam int L_END = ((k + 1) * PIPE_EVERY < LEVELS) ? (k + 1) * PIPE_EVERY : LEVELS;

    if (k < NGRP - 1) begin : g_mid
      logic [WIDTH-1:0] g_q, p_q, x_q;
      logic             c0_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          g_q  <= '0;
          p_q  <= '0;
          x_q  <= '0;
          c0_q <= 1'b0;
        end else if (adv) begin
          g_q  <= lvl_g[L_END];
          p_q  <= lvl_p[L_END];
          x_q  <= src_x[k];
          c0_q <= src_c0[k];
        end
      end

      assign src_g[k+1]  = g_q;
      assign src_p[k+1]  = p_q;
      assign src_x[k+1]  = x_q;
      assign src_c0[k+1] = c0_q;
    end else begin : g_last
      logic [WIDTH-1:0] carry_in, s_wrap, s_d, s_q;
      logic             cout_d, ovf_d, cout_q, ovf_q;

      always_comb begin
        carry_in = {lvl_g[LEVELS][WIDTH-2:0], src_c0[k]};
        s_wrap   = src_x[k] ^ carry_in;
        cout_d   = lvl_g[LEVELS][WIDTH-1];
        ovf_d    = cout_d ^ lvl_g[LEVELS][WIDTH-2];
`ifdef ADDER_SAT_EN
        // On overflow both operand signs agree and equal cout.
        if (ovf_d) s_d = cout_d ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        else       s_d = s_wrap;
`else
        s_d = s_wrap;
`endif
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s_q    <= '0;
          cout_q <= 1'b0;
          ovf_q  <= 1'b0;
        end else if (adv) begin
          s_q    <= s_d;
          cout_q <= cout_d;
          ovf_q  <= ovf_d;
        end
      end

      assign s    = s_q;
      assign cout = cout_q;
      assign ovf  = ovf_q;
    end
  end

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Scoreboard bench for pipelined_prefix_adder: directed cases, backpressure,
// mid-operation reset and a three-configuration random parameter sweep.
module tb_pipelined_prefix_adder;

  typedef struct {
    logic [63:0] s;
    logic        cout;
    logic        ovf;
  } exp_t;

  localparam int LAT0 = 1 + ($clog2(32) + 2 - 1) / 2;

`ifdef ADDER_SAT_EN
  localparam logic [63:0] POS_OVF_S = 64'h7FFF_FFFF;
  localparam logic [63:0] NEG_OVF_S = 64'h8000_0000;
`else
  localparam logic [63:0] POS_OVF_S = 64'h8000_0000;
  localparam logic [63:0] NEG_OVF_S = 64'h7FFF_FFFF;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain (w+1)-bit arithmetic and sign rules.
  function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic cin, input logic sub);
    exp_t        e;
    logic [64:0] mask, bb, sum;
    mask  = (65'd1 << w) - 65'd1;
    bb    = (sub ? {1'b0, ~b} : {1'b0, b}) & mask;
    sum   = ({1'b0, a} & mask) + bb + (sub ? 65'd1 : {64'd0, cin});
    e.s    = sum[63:0] & mask[63:0];
    e.cout = sum[w];
    e.ovf  = (a[w-1] == bb[w-1]) && (e.s[w-1] != a[w-1]);
`ifdef ADDER_SAT_EN
    if (e.ovf) e.s = a[w-1] ? (64'd1 << (w - 1)) : (mask[63:0] >> 1);
`endif
    return e;
  endfunction

  // ---------------- main DUT: WIDTH=32, PIPE_EVERY=2 ----------------
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [31:0] a, b, s;
  exp_t        q0[$];

  pipelined_prefix_adder #(.WIDTH(32), .PIPE_EVERY(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf)
  );

  // Monitor: pops on every output transfer, and checks hold stability under stall.
  initial begin : mon0
    logic        held = 1'b0;
    logic [31:0] h_s;
    logic        h_c, h_o;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        if (held && out_valid) begin
          check("stable_s", s, h_s);
          check("stable_cout", cout, h_c);
          check("stable_ovf", ovf, h_o);
        end
        held = out_valid && !out_ready;
        h_s = s; h_c = cout; h_o = ovf;
        if (out_valid && out_ready) begin
          if (q0.size() == 0) begin
            check("unexpected_out", out_valid, 1'b0);
          end else begin
            e = q0.pop_front();
            check("s", s, e.s);
            check("cout", cout, e.cout);
            check("ovf", ovf, e.ovf);
          end
        end
      end
    end
  end

  // Called just after a posedge; returns just after the posedge that took the op.
  task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic c,
                      input logic sb, input exp_t e);
    bit done = 0;
    in_valid = 1'b1; a = av; b = bv; cin = c; sub = sb;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        q0.push_back(e);
        done = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("send_accepted", done, 1'b1);
  endtask

  task automatic issue(input logic [31:0] av, input logic [31:0] bv, input logic c, input logic sb);
    send(av, bv, c, sb, model(32, 64'(av), 64'(bv), c, sb));
  endtask

  task automatic issue_exp(input logic [31:0] av, input logic [31:0] bv, input logic c,
                           input logic sb, input logic [63:0] es, input logic ec, input logic eo);
    exp_t e;
    e.s = es; e.cout = ec; e.ovf = eo;
    send(av, bv, c, sb, e);
  endtask

  // Cycles from the op's presentation cycle until out_valid is seen.
  task automatic measure_lat(input string name, input int exp_lat);
    int n    = 1;
    bit seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
      else begin
        @(posedge clk); #1;
        n++;
      end
    end
    check(name, n, exp_lat);
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 100 && q0.size() != 0; k++) @(posedge clk);
    #1;
    check(name, q0.size(), 0);
  endtask

  // ---------------- sweep DUTs ----------------
  bit sweep_go = 0;
  bit sw_done [3];

  for (genvar c = 0; c < 3; c++) begin : g_sw
    localparam int W  = (c == 0) ? 8 : (c == 1) ? 24 : 64;
    localparam int PE = (c == 0) ? 1 : (c == 1) ? 3 : 6;

    logic         iv, ir, ci, sb, ov, orr, co, of;
    logic [W-1:0] av, bv, sv;
    exp_t         sq[$];

    pipelined_prefix_adder #(.WIDTH(W), .PIPE_EVERY(PE)) u_sw (
      .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir),
      .a(av), .b(bv), .cin(ci), .sub(sb), .out_valid(ov), .out_ready(orr),
      .s(sv), .cout(co), .ovf(of)
    );

    initial begin : drv
      int sent = 0;
      bit took = 0;
      iv = 1'b0; orr = 1'b1; av = '0; bv = '0; ci = 1'b0; sb = 1'b0;
      sw_done[c] = 1'b0;
      wait (sweep_go);
      @(posedge clk); #1;
      for (int cyc = 0; cyc < 20000 && sent < 1000; cyc++) begin
        if (!iv || took) begin
          iv = ($urandom_range(0, 3) != 0);
          av = W'({$urandom(), $urandom()});
          bv = W'({$urandom(), $urandom()});
          if ($urandom_range(0, 7) == 0) av = '1;
          if ($urandom_range(0, 7) == 0) bv = '0;
          ci = 1'($urandom_range(0, 1));
          sb = 1'($urandom_range(0, 1));
        end
        orr  = ($urandom_range(0, 3) != 0);
        took = 0;
        @(negedge clk);
        if (iv && ir) begin
          sq.push_back(model(W, 64'(av), 64'(bv), ci, sb));
          sent++;
          took = 1;
        end
        @(posedge clk); #1;
      end
      iv = 1'b0; orr = 1'b1;
      for (int k = 0; k < 50 && sq.size() != 0; k++) @(posedge clk);
      #1;
      check($sformatf("w%0d_sent", W), sent, 1000);
      check($sformatf("w%0d_drained", W), sq.size(), 0);
      sw_done[c] = 1'b1;
    end

    initial begin : mon
      logic         held = 1'b0;
      logic [W-1:0] h_s;
      exp_t         e;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          held = 1'b0;
        end else begin
          if (held && ov) check($sformatf("w%0d_stable_s", W), 64'(sv), 64'(h_s));
          held = ov && !orr;
          h_s  = sv;
          if (ov && orr) begin
            if (sq.size() == 0) begin
              check($sformatf("w%0d_unexpected_out", W), ov, 1'b0);
            end else begin
              e = sq.pop_front();
              check($sformatf("w%0d_s", W), 64'(sv), e.s);
              check($sformatf("w%0d_cout", W), co, e.cout);
              check($sformatf("w%0d_ovf", W), of, e.ovf);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_s", s, 32'h0);
    check("rst_cout", cout, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // Basic add with latency measurement, then the cin=0 variant.
    issue_exp(32'hC090F0D0, 32'hCF00FADB, 1'b1, 1'b0, 64'h8F91EBAC, 1'b1, 1'b0);
    measure_lat("latency", LAT0);
    issue_exp(32'hC090F0D0, 32'hCF00FADB, 1'b0, 1'b0, 64'h8F91EBAB, 1'b1, 1'b0);
    // Full carry ripple, subtract (cin ignored), and both overflow directions.
    issue_exp(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 64'h00000000, 1'b1, 1'b0);
    issue_exp(32'h00000005, 32'h00000007, 1'b0, 1'b1, 64'hFFFFFFFE, 1'b0, 1'b0);
    issue_exp(32'h00000005, 32'h00000007, 1'b1, 1'b1, 64'hFFFFFFFE, 1'b0, 1'b0);
    issue_exp(32'h7FFFFFFF, 32'h00000000, 1'b1, 1'b0, POS_OVF_S, 1'b0, 1'b1);
    issue_exp(32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, NEG_OVF_S, 1'b1, 1'b1);
    drain("drain_directed");

    // Backpressure: 8 back-to-back random ops with a 3-cycle stall mid-stream.
    fork
      begin
        for (int i = 0; i < 8; i++)
          issue($urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("stall_in_ready", in_ready, 1'b0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain("drain_backpressure");

    // Reset with a result at the output and three more in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue($urandom(), $urandom(), 1'b1, 1'b0);
    check("pre_rst_out_valid", out_valid, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("async_out_valid", out_valid, 1'b0);
    check("async_s", s, 32'h0);
    check("async_cout", cout, 1'b0);
    check("async_ovf", ovf, 1'b0);
    q0.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1'b1);
    check("post_rst_out_valid", out_valid, 1'b0);
    @(posedge clk); #1;
    issue(32'h12345678, 32'h0FEDCBA9, 1'b0, 1'b0);
    measure_lat("post_rst_latency", LAT0);
    drain("drain_post_rst");
    repeat (8) @(posedge clk);
    #1;

    // Parameter sweep on the three extra configurations.
    sweep_go = 1'b1;
    for (int k = 0; k < 40000 && !(sw_done[0] && sw_done[1] && sw_done[2]); k++) @(posedge clk);
    #1;
    check("sweep_complete", {sw_done[0], sw_done[1], sw_done[2]}, 3'b111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
